rgb888_to_565_stream: RTL



---
 rtl/rgb_stream_pkg.sv | 34 +++
 rtl/rgb888_to_565_pixel.sv | 51 +++++
 rtl/rgb888_to_565_stream.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rgb_stream_pkg.sv
// Shared widths, field offsets and quantisation constants for the RGB888 -> RGB565 stream path.
// Pure definitions: no logic, no latency.
// No flow control.
package rgb_stream_pkg;

    localparam int RGB888_W = 32;
    localparam int RGB565_W = 16;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_NEAREST = 1;

    // Byte lanes inside a 0BGR888 pixel word
    localparam int R_OFF = 0;
    localparam int G_OFF = 8;
    localparam int B_OFF = 16;

    // Field positions inside an RGB565 word ({B5, G6, R5})
    localparam int R5_OFF = 0;
    localparam int G6_OFF = 5;
    localparam int B5_OFF = 11;

    // 2x2 ordered dither: k = {line_parity, column_parity}
    function automatic logic [1:0] dither_off(input logic [1:0] k);
        logic [1:0] d;
        case (k)
            2'd0:    d = 2'd0;
            2'd1:    d = 2'd2;
            2'd2:    d = 2'd3;
            default: d = 2'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rgb888_to_565_pixel.sv
// Single-pixel 0BGR888 -> RGB565 quantiser: truncate, round-to-nearest or ordered dither.
// Combinational, zero latency.
// No flow control; the parent registers the result.
module rgb888_to_565_pixel
    import rgb_stream_pkg::*;
(
    input  logic [RGB888_W-1:0] i_pix,
    input  logic                i_round,
    input  logic                i_dith_en,
    input  logic [1:0]          i_dith,
    output logic [RGB565_W-1:0] o_pix
);

    logic [7:0] w_add_rb;
    logic [7:0] w_add_g;
    logic [8:0] w_sum_r;
    logic [8:0] w_sum_g;
    logic [8:0] w_sum_b;
    logic [7:0] w_sat_r;
    logic [7:0] w_sat_g;
    logic [7:0] w_sat_b;
    logic       w_unused_bits;

    // Truncation is the zero-offset case of the same add/saturate/shift datapath
    always_comb begin
        w_add_rb = 8'd0;
        w_add_g  = 8'd0;
        if (i_dith_en) begin
            w_add_rb = {5'd0, i_dith, 1'b0};
            w_add_g  = {6'd0, i_dith};
        end else if (i_round) begin
            w_add_rb = 8'd4;
            w_add_g  = 8'd2;
        end
    end

    assign w_sum_r = {1'b0, i_pix[R_OFF +: 8]} + {1'b0, w_add_rb};
    assign w_sum_g = {1'b0, i_pix[G_OFF +: 8]} + {1'b0, w_add_g};
    assign w_sum_b = {1'b0, i_pix[B_OFF +: 8]} + {1'b0, w_add_rb};

    assign w_sat_r = w_sum_r[8] ? 8'hFF : w_sum_r[7:0];
    assign w_sat_g = w_sum_g[8] ? 8'hFF : w_sum_g[7:0];
    assign w_sat_b = w_sum_b[8] ? 8'hFF : w_sum_b[7:0];

    assign o_pix[R5_OFF +: 5] = w_sat_r[7:3];
    assign o_pix[G6_OFF +: 6] = w_sat_g[7:2];
    assign o_pix[B5_OFF +: 5] = w_sat_b[7:3];

    assign w_unused_bits = ^{i_pix[31:24], w_sat_r[2:0], w_sat_g[1:0], w_sat_b[2:0]};

endmodule

// File: rtl/rgb888_to_565_stream.sv
// AXI4-Stream 0BGR888 -> RGB565 packer with line-length checking; optional dither via RGB565_DITHER_EN.
// Latency 1 cycle accept -> m_tvalid, 1 beat/cycle under continuous m_tready.
// Skid register absorbs one beat under stall; s_tready is registered and drops while the skid is full.
module rgb888_to_565_stream
    import rgb_stream_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 4,
    parameter int ROUND_MODE      = 0,
    parameter int BEATS_PER_LINE  = 0,
    parameter int CNT_W           = 16
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                s_tvalid,
    output logic                                s_tready,
    input  logic                                s_tlast,
    input  logic [RGB888_W*PIXELS_PER_BEAT-1:0] rgb888_in,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic                                m_tlast,
    output logic [RGB565_W*PIXELS_PER_BEAT-1:0] rgb565_out,
    output logic                                tlast_err
);

    localparam int              DW       = RGB565_W * PIXELS_PER_BEAT;
    localparam int              LAST_IDX = (BEATS_PER_LINE > 0) ? BEATS_PER_LINE - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);
    localparam logic            CHK_EN   = (BEATS_PER_LINE > 0);
    localparam logic            RND_EN   = (ROUND_MODE == ROUND_NEAREST);

    logic [DW-1:0]    w_conv;
    logic             w_accept;
    logic             w_main_free;
    logic             w_at_end;
    logic [DW-1:0]    r_main_dat;
    logic [DW-1:0]    r_skid_dat;
    logic             r_main_vld;
    logic             r_skid_vld;
    logic             r_main_last;
    logic             r_skid_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_line_par;
    logic             r_err;

    for (genvar g = 0; g < PIXELS_PER_BEAT; g++) begin : g_lane
        logic       w_dith_en;
        logic [1:0] w_dith;
`ifdef RGB565_DITHER_EN
        localparam logic PPB_ODD  = 1'(PIXELS_PER_BEAT % 2);
        localparam logic LANE_ODD = 1'(g % 2);
        // Column parity of beat_count*PPB + lane needs only the LSBs
        assign w_dith_en = 1'b1;
        assign w_dith    = dither_off({r_line_par, (r_cnt[0] & PPB_ODD) ^ LANE_ODD});
`else
        assign w_dith_en = 1'b0;
        assign w_dith    = 2'd0;
`endif
        rgb888_to_565_pixel u_pix (
            .i_pix     (rgb888_in[RGB888_W*g +: RGB888_W]),
            .i_round   (RND_EN),
            .i_dith_en (w_dith_en),
            .i_dith    (w_dith),
            .o_pix     (w_conv[RGB565_W*g +: RGB565_W])
        );
    end

`ifndef RGB565_DITHER_EN
    logic w_unused_par;
    assign w_unused_par = r_line_par;
`endif

    assign s_tready    = ~r_skid_vld;
    assign w_accept    = s_tvalid & ~r_skid_vld;
    assign w_main_free = ~r_main_vld | m_tready;
    assign m_tvalid    = r_main_vld;
    assign m_tlast     = r_main_last;
    assign rgb565_out  = r_main_dat;
    assign tlast_err   = r_err;

    // While the skid is full no beat can be accepted, so it only drains
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_main_vld  <= 1'b0;
            r_main_last <= 1'b0;
            r_main_dat  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_skid_dat  <= '0;
        end else if (r_skid_vld) begin
            if (m_tready) begin
                r_main_dat  <= r_skid_dat;
                r_main_last <= r_skid_last;
                r_skid_vld  <= 1'b0;
            end
        end else if (w_accept) begin
            if (w_main_free) begin
                r_main_dat  <= w_conv;
                r_main_last <= s_tlast;
                r_main_vld  <= 1'b1;
            end else begin
                r_skid_dat  <= w_conv;
                r_skid_last <= s_tlast;
                r_skid_vld  <= 1'b1;
            end
        end else if (m_tready) begin
            r_main_vld <= 1'b0;
        end
    end

    assign w_at_end = CHK_EN && (r_cnt == LAST_CNT);

    // A missing tlast restarts the count as if the line had ended
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt      <= '0;
            r_line_par <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_err <= s_tlast ? (CHK_EN && !w_at_end) : w_at_end;
            r_cnt <= (s_tlast || w_at_end) ? '0 : r_cnt + CNT_W'(1);
            if (s_tlast) begin
                r_line_par <= ~r_line_par;
            end
        end else begin
            r_err <= 1'b0;
        end
    end

endmodule
